candy_if: RTL
=============

Name: candy_if

Overview:
- Instruction fetch stage of the candy core; sits directly upstream of the decode stage.
- Maintains the PC and issues 24-bit instruction reads to instruction memory over a request/response handshake.
- Buffers returned words in a small prefetch FIFO and presents them to decode with a valid/ready pair.
- Redirect input (branch/jump from execute) flushes the FIFO, squashes any in-flight read, and restarts fetch at the target.

Parameters:
- INST_W, 24, instruction width (matches decode's inst bus)
- PC_W, 16, program counter / instruction address width, word addressed
- DEPTH, 2, prefetch FIFO entries (power of two, >=2)
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
- imem_req  out  1  read request valid
- imem_addr  out  PC_W  read word address, stable while imem_req && !imem_ready
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid, >=1 cycle after acceptance, in order
- imem_rdata  in  INST_W  read data
- branch_en  in  1  redirect strobe, one cycle
- branch_target  in  PC_W  redirect address
- inst  out  INST_W  instruction to decode (FIFO head)
- inst_pc  out  PC_W  address of inst
- id_enable  out  1  inst/inst_pc valid
- id_ready  in  1  decode consumes head this cycle when id_enable && id_ready

Behaviour:
- Reset: pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, imem_addr=RESET_PC, id_enable=0, inst=0, inst_pc=0, drop=0.
- At most one outstanding read. Issue only when count + outstanding < DEPTH (credit rule); FIFO can never overflow.
- FSM:
  - IDLE: imem_req=0. Goes to REQ when credit is available and no redirect this cycle.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready: pc<=pc+1 (wraps modulo 2^PC_W), go to WAIT.
  - WAIT: on imem_rvalid, if drop=0 enqueue {rdata, address}; if drop=1 discard and clear drop. Then go to REQ if credit remains, else IDLE.
- Outputs:
  - id_enable = FIFO non-empty.
  - inst/inst_pc = head entry, registered.
  - Dequeue on id_enable && id_ready.
  - Simultaneous enqueue and dequeue is allowed, including at full (count unchanged).
- Latency: rvalid in cycle k -> id_enable in cycle k+1 when the FIFO was empty.
- Redirect (branch_en=1), which has priority over all other events in the same cycle:
  - FIFO cleared. The head presented in that cycle is void even if id_ready=1.
  - pc<=branch_target; state<=REQ; imem_req is asserted at branch_target in the next cycle.
  - If redirect arrives in REQ with imem_ready=1, or in WAIT without rvalid: drop<=1, and the late response is discarded. Re-issue waits for that response (single-outstanding rule): state<=WAIT with drop=1, then REQ.
  - If redirect arrives in WAIT with rvalid=1 the same cycle: the data is discarded, drop stays 0.
  - If redirect arrives in REQ without imem_ready: imem_addr switches to the target next cycle, and the old request is withdrawn.
- Stall: with id_ready=0 the FIFO fills to DEPTH and fetch pauses in IDLE. imem_req is never asserted without credit.
- Reset mid-operation: all state returns to reset values. Any response arriving after reset is ignored (drop is not kept). The memory side is reset in the same domain.

Optional Feature:
- Macro CANDY_IF_PERF_EN.
- When defined:
  - Adds output perf_fetch_cnt (32 bits): increments on every enqueued, non-dropped instruction.
  - Adds output perf_stall_cnt (32 bits): increments each cycle id_enable=1 && id_ready=0.
  - Both counters wrap and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, memory with 1-cycle latency and imem_ready=1, id_ready=1:
  - Requests go to 0,1,2,...
  - id_enable first high 3 cycles after the first request (REQ, WAIT/rvalid, output).
  - inst_pc sequence is 0,1,2 with matching data.
- id_ready held 0 for 10 cycles:
  - Exactly DEPTH=2 words are buffered and imem_req stays 0.
  - On release, pcs 0,1,2 are delivered in order with no gaps or duplicates.
- branch_en with target 16'h0040 while a read of address 5 is outstanding (rvalid 2 cycles later):
  - Data for address 5 is discarded.
  - Next imem_addr is 0x0040.
  - First delivered inst_pc is 0x0040.
- branch_en in the same cycle as rvalid and id_enable && id_ready:
  - FIFO is empty next cycle.
  - No stale pc reaches decode.
  - Fetch resumes at the target.
- pc at 16'hFFFF: the next request is to 16'h0000.
- rst driven low during WAIT, then rvalid arrives: id_enable stays 0 and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/candy_if.sv
// candy_if: instruction fetch stage with a single-outstanding memory read and a small prefetch FIFO.
// Optional performance counters are enabled by defining CANDY_IF_PERF_EN.
module candy_if #(
    parameter int              INST_W   = 24,
    parameter int              PC_W     = 16,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              branch_en,
    input  logic [PC_W-1:0]   branch_target,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              id_enable,
    input  logic              id_ready
`ifdef CANDY_IF_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    // state | meaning
    // IDLE  | no request; waiting for FIFO credit
    // REQ   | imem_req high at pc, waiting for imem_ready
    // WAIT  | one read outstanding, waiting for imem_rvalid
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]        state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt, addr_q;
    logic              drop, drop_nxt;
    logic [INST_W-1:0] mem_data [DEPTH];
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, count_nxt;
    logic              accept, enq, deq;

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    // A redirect voids both the arriving word and the presented head.
    assign enq       = (state == WAIT) && imem_rvalid && !drop && !branch_en;
    assign id_enable = (count != '0);
    assign deq       = id_enable && id_ready && !branch_en;
    assign inst      = mem_data[rd_ptr];
    assign inst_pc   = mem_pc[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (branch_en)
            count_nxt = '0;
        else
            count_nxt = count + {{(CW-1){1'b0}}, enq} - {{(CW-1){1'b0}}, deq};
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        if (branch_en) begin
            pc_nxt    = branch_target;
            state_nxt = REQ;
            drop_nxt  = 1'b0;
            // A read still in flight must drain before the target is issued.
            if (accept || ((state == WAIT) && !imem_rvalid)) begin
                state_nxt = WAIT;
                drop_nxt  = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (count_nxt < DEPTH_C)
                        state_nxt = REQ;
                end
                REQ: begin
                    if (imem_ready) begin
                        pc_nxt    = pc + PC_W'(1);
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop_nxt  = 1'b0;
                        state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            drop   <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            drop  <= drop_nxt;
            count <= count_nxt;
            if (accept)
                addr_q <= pc;
            if (enq) begin
                mem_data[wr_ptr] <= imem_rdata;
                mem_pc[wr_ptr]   <= addr_q;
            end
            if (branch_en) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (enq)
                    wr_ptr <= wr_ptr + AW'(1);
                if (deq)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

`ifdef CANDY_IF_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (enq)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (id_enable && !id_ready)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
